modbus_frame_check: RTL and testbench
=====================================

MODBUS_FRAME_CHECK -- requirements
Module: modbus_frame_check

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 8'h01, meaning the slave address this node answers to.
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 RX_Data  input  56  received frame: [7:0] addr, [15:8] func, [23:16] data0, [31:24] data1, [39:32] data2, [47:40] CRC low, [55:48] CRC high.
REQ-005 RX_Done_Sig  input  1  one-cycle pulse; RX_Data is stable and complete while it is high.
REQ-006 Busy_Sig  output  1  high while a frame is being checked.
REQ-007 Frame_Valid_Sig  output  1  one-cycle pulse: frame passed CRC and address checks.
REQ-008 Frame_Err_Sig  output  1  one-cycle pulse: frame rejected.
REQ-009 Err_Code  output  2  00 none, 01 CRC mismatch, 10 address mismatch, 11 overrun.
REQ-010 Func_Code  output  8  function byte of the last accepted frame.
REQ-011 Payload  output  24  {data2,data1,data0} of the last accepted frame.

Function
REQ-012 States SHALL be IDLE, XOR, SHIFT and CHECK.
REQ-013 IDLE: when RX_Done_Sig=1, the block SHALL latch RX_Data, set crc=16'hFFFF, set byte index=0, set Busy_Sig=1 and go to XOR.
REQ-014 XOR: the block SHALL set crc = crc ^ byte[index], clear the bit counter and go to SHIFT.
REQ-015 SHIFT: each cycle the block SHALL set crc = (crc>>1) ^ (crc[0] ? 16'hA001 : 0), for exactly 8 cycles.
REQ-016 After the 8th shift the block SHALL go to CHECK if index==4; otherwise it SHALL increment index and return to XOR.
REQ-017 CRC coverage SHALL be bytes 0-4 only, which takes 45 processing cycles.
REQ-018 CHECK SHALL compare crc against {RX_Data[55:48],RX_Data[47:40]} and compare the address against DEV_ADDR, then return to IDLE and clear Busy_Sig.
REQ-019 Exactly one of Frame_Valid_Sig or Frame_Err_Sig SHALL pulse per frame, high for 1 cycle beginning 46 cycles after the edge that sampled RX_Done_Sig.
REQ-020 Error priority SHALL be CRC (01) over address (10).
REQ-021 Err_Code SHALL update with each pulse and hold until the next pulse.
REQ-022 Func_Code and Payload SHALL update only on a valid frame and otherwise hold their value.
REQ-023 If RX_Done_Sig=1 while Busy_Sig=1, the new frame SHALL be dropped and Frame_Err_Sig with Err_Code=11 SHALL pulse the next cycle.
REQ-024 An overrun SHALL NOT disturb the frame in progress.
REQ-025 If an overrun pulse and the CHECK result fall in the same cycle, the CHECK result SHALL be reported that cycle and the overrun report SHALL be issued the following cycle.
REQ-026 A back-to-back RX_Done_Sig arriving in the cycle immediately after CHECK SHALL be accepted normally.

Reset
REQ-027 RSTn=0 SHALL asynchronously force: state IDLE, crc 16'hFFFF, index 0, Busy_Sig 0, Frame_Valid_Sig 0, Frame_Err_Sig 0, Err_Code 00, Func_Code 8'h00, Payload 24'h0.
REQ-028 Reset mid-check SHALL abandon the frame with no pulse issued after release.

Configuration
REQ-029 Macro MB_BCAST_EN SHALL control broadcast-address support.
REQ-030 With MB_BCAST_EN defined, address 8'h00 SHALL also pass the address check.
REQ-031 Without MB_BCAST_EN, only DEV_ADDR SHALL pass; 8'h00 SHALL yield Err_Code=10.

Verification
REQ-032 RX_Data=56'h83990A00000301 with RX_Done pulse -> Frame_Valid_Sig pulse at cycle 46, Func_Code=8'h03, Payload=24'h0A0000, Err_Code=00.
REQ-033 Same frame with byte 6 changed to 8'h84 -> Frame_Err_Sig pulse at cycle 46, Err_Code=01, Func_Code/Payload unchanged.
REQ-034 Valid-CRC frame with addr 8'h05 -> Err_Code=10; if its CRC is also corrupted -> Err_Code=01.
REQ-035 Second RX_Done pulse at cycle 20 of a check -> Err_Code=11 pulse at cycle 21, then the first frame's result at cycle 46.
REQ-036 RSTn low at cycle 30 -> all outputs at reset values and no pulse; a fresh frame afterward checks correctly.
REQ-037 Addr 8'h00 frame with correct CRC -> valid if MB_BCAST_EN is defined, else Err_Code=10.

Source files
------------

// File: rtl/modbus_frame_check_if.sv
// Receive-side frame bus between a Modbus RTU byte assembler and modbus_frame_check.
// Carries the completed 7-byte frame in, and the check verdict, latched fields and FSM state out.
interface modbus_frame_check_if;
  // RX_Done_Sig is a valid-only pulse: there is no ready. RX_Data must be stable while it
  // is high. A frame offered while Busy_Sig=1 is dropped and reported as an overrun.
  logic [55:0] RX_Data;
  logic        RX_Done_Sig;
  logic        Busy_Sig;
  logic        Frame_Valid_Sig;
  logic        Frame_Err_Sig;
  logic [1:0]  Err_Code;
  logic [7:0]  Func_Code;
  logic [23:0] Payload;
  logic [1:0]  dbg_state;

  modport master (
    output RX_Data, RX_Done_Sig,
    input  Busy_Sig, Frame_Valid_Sig, Frame_Err_Sig, Err_Code, Func_Code, Payload, dbg_state
  );

  modport slave (
    input  RX_Data, RX_Done_Sig,
    output Busy_Sig, Frame_Valid_Sig, Frame_Err_Sig, Err_Code, Func_Code, Payload, dbg_state
  );
endinterface

// File: rtl/modbus_frame_check.sv
// Modbus RTU frame checker: bit-serial CRC-16 (poly 0xA001) over bytes 0-4 plus address match.
// Optional macro MB_BCAST_EN lets broadcast address 8'h00 pass the address check.
module modbus_frame_check #(
    parameter logic [7:0] DEV_ADDR = 8'h01
) (
    input logic            CLK,
    input logic            RSTn,
    modbus_frame_check_if.slave bus
);

    typedef enum logic [1:0] {IDLE, XOR, SHIFT, CHECK} state_t;

    state_t      state_q, state_n;
    logic [55:0] frame_q, frame_n;
    logic [15:0] crc_q, crc_n;
    logic [2:0]  idx_q, idx_n;
    logic [2:0]  bit_q, bit_n;
    logic        busy_q, busy_n;
    logic        valid_q, valid_n;
    logic        err_q, err_n;
    logic [1:0]  code_q, code_n;
    logic [7:0]  func_q, func_n;
    logic [23:0] pay_q, pay_n;
    logic        ovr_q, ovr_n;

    logic [7:0]  cur_byte;
    logic        crc_ok;
    logic        addr_ok;

    always_comb begin
        case (idx_q)
            3'd0:    cur_byte = frame_q[7:0];
            3'd1:    cur_byte = frame_q[15:8];
            3'd2:    cur_byte = frame_q[23:16];
            3'd3:    cur_byte = frame_q[31:24];
            default: cur_byte = frame_q[39:32];
        endcase
    end

    // The CRC is sent low byte first, so the received word is {high, low}.
    assign crc_ok = (crc_q == {frame_q[55:48], frame_q[47:40]});

`ifdef MB_BCAST_EN
    assign addr_ok = (frame_q[7:0] == DEV_ADDR) || (frame_q[7:0] == 8'h00);
`else
    assign addr_ok = (frame_q[7:0] == DEV_ADDR);
`endif

    always_comb begin
        state_n = state_q;
        frame_n = frame_q;
        crc_n   = crc_q;
        idx_n   = idx_q;
        bit_n   = bit_q;
        busy_n  = busy_q;
        valid_n = 1'b0;
        err_n   = 1'b0;
        code_n  = code_q;
        func_n  = func_q;
        pay_n   = pay_q;
        ovr_n   = ovr_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_Done_Sig) begin
                    frame_n = bus.RX_Data;
                    crc_n   = 16'hFFFF;
                    idx_n   = 3'd0;
                    busy_n  = 1'b1;
                    state_n = XOR;
                end
            end
            XOR: begin
                crc_n   = crc_q ^ {8'h00, cur_byte};
                bit_n   = 3'd0;
                state_n = SHIFT;
            end
            SHIFT: begin
                crc_n = (crc_q >> 1) ^ (crc_q[0] ? 16'hA001 : 16'h0000);
                bit_n = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    if (idx_q == 3'd4) begin
                        state_n = CHECK;
                    end else begin
                        idx_n   = idx_q + 3'd1;
                        state_n = XOR;
                    end
                end
            end
            CHECK: begin
                busy_n  = 1'b0;
                state_n = IDLE;
                if (!crc_ok) begin
                    err_n  = 1'b1;
                    code_n = 2'b01;
                end else if (!addr_ok) begin
                    err_n  = 1'b1;
                    code_n = 2'b10;
                end else begin
                    valid_n = 1'b1;
                    code_n  = 2'b00;
                    func_n  = frame_q[15:8];
                    pay_n   = frame_q[39:16];
                end
            end
            default: state_n = IDLE;
        endcase

        // A pending overrun yields to the CHECK verdict and goes out one cycle later.
        if (ovr_q && (state_q != CHECK)) begin
            err_n  = 1'b1;
            code_n = 2'b11;
            ovr_n  = 1'b0;
        end
        if (bus.RX_Done_Sig && (state_q != IDLE)) begin
            ovr_n = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            frame_q <= 56'h0;
            crc_q   <= 16'hFFFF;
            idx_q   <= 3'd0;
            bit_q   <= 3'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            func_q  <= 8'h00;
            pay_q   <= 24'h0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            frame_q <= frame_n;
            crc_q   <= crc_n;
            idx_q   <= idx_n;
            bit_q   <= bit_n;
            busy_q  <= busy_n;
            valid_q <= valid_n;
            err_q   <= err_n;
            code_q  <= code_n;
            func_q  <= func_n;
            pay_q   <= pay_n;
            ovr_q   <= ovr_n;
        end
    end

    assign bus.Busy_Sig        = busy_q;
    assign bus.Frame_Valid_Sig = valid_q;
    assign bus.Frame_Err_Sig   = err_q;
    assign bus.Err_Code        = code_q;
    assign bus.Func_Code       = func_q;
    assign bus.Payload         = pay_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_modbus_frame_check.sv
// Directed bench for modbus_frame_check: CRC/address verdicts, latency, overrun ordering, reset.
// Frame CRCs below are hand-computed CRC-16/Modbus values over bytes 0-4.
module tb_modbus_frame_check;

  localparam logic [55:0] F_OK        = 56'h83990A00000301;
  localparam logic [55:0] F_BADCRC    = 56'h84990A00000301;
  localparam logic [55:0] F_ADDR5     = 56'h43680A00000305;
  localparam logic [55:0] F_ADDR5_BAD = 56'h43690A00000305;
  localparam logic [55:0] F_BCAST     = 56'h43A40A00000300;

  logic CLK = 1'b0;
  logic RSTn;
  int   n_checks = 0;
  int   n_errors = 0;

  modbus_frame_check_if bus();

  modbus_frame_check #(.DEV_ADDR(8'h01)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Offer one frame; returns 1 time unit after the sampling edge.
  task automatic pulse_rx(input logic [55:0] d);
    bus.RX_Data     = d;
    bus.RX_Done_Sig = 1'b1;
    step();
    bus.RX_Done_Sig = 1'b0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(bus.Frame_Valid_Sig || bus.Frame_Err_Sig) && n < 80);
  endtask

  task automatic expect_result(input string tag, input int lat, input logic v,
                               input logic [1:0] code, input logic [7:0] func,
                               input logic [23:0] pay);
    int n;
    wait_pulse(n);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_valid"}, bus.Frame_Valid_Sig, v);
    chk({tag, "_err"}, bus.Frame_Err_Sig, !v);
    chk({tag, "_code"}, bus.Err_Code, code);
    chk({tag, "_func"}, bus.Func_Code, func);
    chk({tag, "_payload"}, bus.Payload, pay);
    chk({tag, "_busy_clr"}, bus.Busy_Sig, 1'b0);
    step();
    chk({tag, "_pulse_end"}, bus.Frame_Valid_Sig | bus.Frame_Err_Sig, 1'b0);
    chk({tag, "_code_hold"}, bus.Err_Code, code);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, bus.Busy_Sig, 1'b0);
    chk({tag, "_valid"}, bus.Frame_Valid_Sig, 1'b0);
    chk({tag, "_err"}, bus.Frame_Err_Sig, 1'b0);
    chk({tag, "_code"}, bus.Err_Code, 2'b00);
    chk({tag, "_func"}, bus.Func_Code, 8'h00);
    chk({tag, "_payload"}, bus.Payload, 24'h0);
    chk({tag, "_state"}, bus.dbg_state, 2'd0);
  endtask

  initial begin
    int n;
    int n_pulse;

    RSTn            = 1'b0;
    bus.RX_Data     = 56'h0;
    bus.RX_Done_Sig = 1'b0;
    #23;
    chk_reset_vals("por");
    @(negedge CLK);
    RSTn = 1'b1;
    step();

    // Good frame: CRC 0x8399, address 0x01.
    pulse_rx(F_OK);
    chk("ok_busy_set", bus.Busy_Sig, 1'b1);
    expect_result("ok", 46, 1'b1, 2'b01 ^ 2'b01, 8'h03, 24'h0A0000);

    // Bad CRC: fields must hold from the previous accepted frame.
    pulse_rx(F_BADCRC);
    expect_result("badcrc", 46, 1'b0, 2'b01, 8'h03, 24'h0A0000);

    pulse_rx(F_ADDR5);
    expect_result("addr5", 46, 1'b0, 2'b10, 8'h03, 24'h0A0000);

    // CRC error outranks address error.
    pulse_rx(F_ADDR5_BAD);
    expect_result("addr5_badcrc", 46, 1'b0, 2'b01, 8'h03, 24'h0A0000);

    pulse_rx(F_BCAST);
`ifdef MB_BCAST_EN
    expect_result("bcast", 46, 1'b1, 2'b00, 8'h03, 24'h0A0000);
`else
    expect_result("bcast", 46, 1'b0, 2'b10, 8'h03, 24'h0A0000);
`endif

    // Overrun at cycle 20 of a good frame; the dropped frame has a bad CRC.
    pulse_rx(F_OK);
    repeat (19) step();
    pulse_rx(F_BADCRC);
    chk("ovr20_no_early", bus.Frame_Valid_Sig | bus.Frame_Err_Sig, 1'b0);
    step();
    chk("ovr20_err", bus.Frame_Err_Sig, 1'b1);
    chk("ovr20_valid", bus.Frame_Valid_Sig, 1'b0);
    chk("ovr20_code", bus.Err_Code, 2'b11);
    chk("ovr20_busy", bus.Busy_Sig, 1'b1);
    wait_pulse(n);
    chk("ovr20_first_latency", n + 21, 46);
    chk("ovr20_first_valid", bus.Frame_Valid_Sig, 1'b1);
    chk("ovr20_first_code", bus.Err_Code, 2'b00);
    step();

    // Overrun coinciding with CHECK, then a back-to-back frame right after CHECK.
    pulse_rx(F_BADCRC);
    repeat (44) step();
    pulse_rx(F_OK);
    chk("coll_no_early", bus.Frame_Valid_Sig | bus.Frame_Err_Sig, 1'b0);
    step();
    chk("coll_check_err", bus.Frame_Err_Sig, 1'b1);
    chk("coll_check_code", bus.Err_Code, 2'b01);
    pulse_rx(F_ADDR5);
    chk("coll_ovr_err", bus.Frame_Err_Sig, 1'b1);
    chk("coll_ovr_code", bus.Err_Code, 2'b11);
    chk("b2b_busy", bus.Busy_Sig, 1'b1);
    expect_result("b2b", 46, 1'b0, 2'b10, 8'h03, 24'h0A0000);

    // Reset at cycle 30 of a frame.
    pulse_rx(F_OK);
    repeat (29) step();
    #2;
    RSTn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    @(negedge CLK);
    RSTn    = 1'b1;
    n_pulse = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.Frame_Valid_Sig || bus.Frame_Err_Sig) n_pulse++;
    end
    chk("midrst_no_pulse", n_pulse, 0);
    chk("midrst_idle", bus.dbg_state, 2'd0);

    pulse_rx(F_OK);
    expect_result("after_rst", 46, 1'b1, 2'b00, 8'h03, 24'h0A0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
